serial_subtractor: RTL

//   Bit-serial N-bit subtractor: computes diff = a - b, LSB first, one bit per clock.

---
 rtl/serial_subtractor_pkg.sv | 18 +
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W     = $clog2(WIDTH_DEF);

  // Bit-counter width for an arbitrary operand width (operands are at least 2 bits).
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational full subtractor: d = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first) with start/busy/done handshake.
// Define SERIAL_SUB_SIGNED_EN to add the registered signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_SIGNED_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    count_q, count_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fs_d, fs_bout;
`ifdef SERIAL_SUB_SIGNED_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  full_subtractor u_fs (
    .x   (a_sh_q[0]),
    .y   (b_sh_q[0]),
    .bin (borrow_q),
    .d   (fs_d),
    .bout(fs_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    diff_d   = diff_q;
    count_d  = count_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      // DONE accepts a new start exactly like IDLE, giving back-to-back operation.
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d  = RUN;
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = 1'b0;
          count_d  = '0;
          busy_d   = 1'b1;
`ifdef SERIAL_SUB_SIGNED_EN
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        diff_d   = {fs_d, diff_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        borrow_d = fs_bout;
        count_d  = count_q + 1'b1;
        busy_d   = 1'b1;
        // The last bit's difference is the result MSB, so overflow is decided here.
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bout_d  = fs_bout;
`ifdef SERIAL_SUB_SIGNED_EN
          ovf_d   = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      diff_q   <= '0;
      count_q  <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      diff_q   <= diff_d;
      count_q  <= count_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_SIGNED_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_SIGNED_EN
  assign ovf  = ovf_q;
`endif

endmodule
